// File: rtl/sa_pkg.sv
// Shared state encoding and accumulator arithmetic for the output-stationary systolic array.
// Build option SA_SATURATE_EN selects saturating accumulation; otherwise sums wrap modulo 2^AW.
package sa_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COMPUTE,
    ST_FLUSH,
    ST_DRAIN
  } sa_state_e;

  localparam int unsigned KW = 16;
  // Working width for accumulator arithmetic; AW must stay below it.
  localparam int unsigned XW = 64;

  // Reinterpret the low aw bits of v as a signed value.
  function automatic logic signed [XW-1:0] sa_sext(input logic signed [XW-1:0] v,
                                                   input int unsigned aw);
    logic signed [XW-1:0] t;
    t = v <<< (XW - aw);
    return t >>> (XW - aw);
  endfunction

  function automatic logic sa_ovf(input logic signed [XW-1:0] sum, input int unsigned aw);
    return sa_sext(sum, aw) != sum;
  endfunction

  // Next accumulator value from the full-width sum of accumulator and extended product.
  function automatic logic signed [XW-1:0] sa_acc_next(input logic signed [XW-1:0] sum,
                                                       input int unsigned aw);
    logic signed [XW-1:0] r;
    r = sa_sext(sum, aw);
`ifdef SA_SATURATE_EN
    if (sa_ovf(sum, aw)) begin
      r = sum[XW-1] ? -(XW'(1) <<< (aw - 1)) : (XW'(1) <<< (aw - 1)) - XW'(1);
    end
`endif
    return r;
  endfunction

endpackage

// File: rtl/sa_pe.sv
// One processing element: registered a/w/tag pass-through and a signed multiply-accumulate.
// Build option SA_SATURATE_EN makes a saturated accumulator hold until the next clear.
module sa_pe
  import sa_pkg::*;
#(
  parameter int unsigned DW = 8,
  parameter int unsigned AW = 24
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          acc_clr_i,
  input  logic [DW-1:0] a_i,
  input  logic          a_vld_i,
  input  logic [DW-1:0] w_i,
  input  logic          w_vld_i,
  output logic [DW-1:0] a_o,
  output logic          a_vld_o,
  output logic [DW-1:0] w_o,
  output logic          w_vld_o,
  output logic [AW-1:0] acc_o
);

  logic [DW-1:0]          a_q, w_q;
  logic                   a_vld_q, w_vld_q;
  logic [AW-1:0]          acc_q, acc_d;
  logic signed [2*DW-1:0] prod_c;
  logic signed [XW-1:0]   sum_c;
  logic                   hit_c, upd_c;

  always_comb begin
    prod_c = (2*DW)'($signed(a_i)) * (2*DW)'($signed(w_i));
    sum_c  = XW'(prod_c) + XW'($signed(acc_q));
    acc_d  = AW'(sa_acc_next(sum_c, AW));
    hit_c  = a_vld_i && w_vld_i;
  end

`ifdef SA_SATURATE_EN
  logic sat_q;

  // Sticky saturation flag: once clipped, the accumulator freezes.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sat_q <= 1'b0;
    end else if (acc_clr_i) begin
      sat_q <= 1'b0;
    end else if (hit_c && !sat_q) begin
      sat_q <= sa_ovf(sum_c, AW);
    end
  end

  assign upd_c = hit_c && !sat_q;
`else
  assign upd_c = hit_c;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      a_q     <= '0;
      w_q     <= '0;
      a_vld_q <= 1'b0;
      w_vld_q <= 1'b0;
      acc_q   <= '0;
    end else begin
      a_q     <= a_i;
      w_q     <= w_i;
      a_vld_q <= a_vld_i;
      w_vld_q <= w_vld_i;
      if (acc_clr_i) begin
        acc_q <= '0;
      end else if (upd_c) begin
        acc_q <= acc_d;
      end
    end
  end

  assign a_o     = a_q;
  assign a_vld_o = a_vld_q;
  assign w_o     = w_q;
  assign w_vld_o = w_vld_q;
  assign acc_o   = acc_q;

endmodule

// File: rtl/systolic_array_os.sv
// Output-stationary systolic matmul C = A*W with input skewing, bubble tags and row-serial drain.
// Build option SA_SATURATE_EN (see sa_pkg/sa_pe) selects saturating accumulation.
module systolic_array_os
  import sa_pkg::*;
#(
  parameter int unsigned ROWS = 4,
  parameter int unsigned COLS = 4,
  parameter int unsigned DW   = 8,
  parameter int unsigned AW   = 24,
  localparam int unsigned RW  = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 start,
  input  logic [KW-1:0]        k_len,
  output logic                 busy,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [ROWS*DW-1:0]   in_a,
  input  logic [COLS*DW-1:0]   in_w,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [COLS*AW-1:0]   out_data,
  output logic [RW-1:0]        out_row,
  output logic                 out_last,
  output logic                 done
);

  localparam int unsigned FLUSH_LEN = ROWS + COLS - 1;

  sa_state_e          state_q;
  logic [KW-1:0]      cnt_q;
  logic               in_ready_q, busy_q, out_valid_q, out_last_q, done_q;
  logic [COLS*AW-1:0] out_data_q, sel_row_c;
  logic [RW-1:0]      out_row_q, row_nxt_c, sel_idx_c;
  logic               acc_clr_c, beat_c;

  logic [DW-1:0] a_h  [ROWS][COLS+1];
  logic          av_h [ROWS][COLS+1];
  logic [DW-1:0] w_v  [ROWS+1][COLS];
  logic          wv_v [ROWS+1][COLS];
  logic [AW-1:0] acc_w [ROWS][COLS];

  assign beat_c    = in_valid && in_ready_q;
  assign acc_clr_c = (state_q == ST_IDLE) && start;
  assign row_nxt_c = out_row_q + RW'(1);
  assign sel_idx_c = (state_q == ST_FLUSH) ? '0 : row_nxt_c;

  // Activation skew: row lane i is delayed i cycles along with its valid tag.
  for (genvar i = 0; i < ROWS; i++) begin : g_skew_a
    if (i == 0) begin : g_direct
      assign a_h[0][0]  = in_a[DW-1:0];
      assign av_h[0][0] = beat_c;
    end else begin : g_dly
      logic [DW-1:0] d_q [i];
      logic [i-1:0]  v_q;
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          for (int k = 0; k < i; k++) d_q[k] <= '0;
          v_q <= '0;
        end else begin
          d_q[0] <= in_a[i*DW +: DW];
          for (int k = 1; k < i; k++) d_q[k] <= d_q[k-1];
          v_q <= i'({v_q, beat_c});
        end
      end
      assign a_h[i][0]  = d_q[i-1];
      assign av_h[i][0] = v_q[i-1];
    end
  end

  // Weight skew: column lane j is delayed j cycles along with its valid tag.
  for (genvar j = 0; j < COLS; j++) begin : g_skew_w
    if (j == 0) begin : g_direct
      assign w_v[0][0]  = in_w[DW-1:0];
      assign wv_v[0][0] = beat_c;
    end else begin : g_dly
      logic [DW-1:0] d_q [j];
      logic [j-1:0]  v_q;
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          for (int k = 0; k < j; k++) d_q[k] <= '0;
          v_q <= '0;
        end else begin
          d_q[0] <= in_w[j*DW +: DW];
          for (int k = 1; k < j; k++) d_q[k] <= d_q[k-1];
          v_q <= j'({v_q, beat_c});
        end
      end
      assign w_v[0][j]  = d_q[j-1];
      assign wv_v[0][j] = v_q[j-1];
    end
  end

  for (genvar i = 0; i < ROWS; i++) begin : g_row
    for (genvar j = 0; j < COLS; j++) begin : g_col
      sa_pe #(
        .DW(DW),
        .AW(AW)
      ) u_pe (
        .clk       (clk),
        .rstn      (rstn),
        .acc_clr_i (acc_clr_c),
        .a_i       (a_h[i][j]),
        .a_vld_i   (av_h[i][j]),
        .w_i       (w_v[i][j]),
        .w_vld_i   (wv_v[i][j]),
        .a_o       (a_h[i][j+1]),
        .a_vld_o   (av_h[i][j+1]),
        .w_o       (w_v[i+1][j]),
        .w_vld_o   (wv_v[i+1][j]),
        .acc_o     (acc_w[i][j])
      );
    end
  end

  // Pass-through outputs leaving the array edge carry nothing further.
  logic unused_edge_c;
  always_comb begin
    unused_edge_c = 1'b0;
    for (int i = 0; i < ROWS; i++) unused_edge_c = unused_edge_c ^ (^a_h[i][COLS]) ^ av_h[i][COLS];
    for (int j = 0; j < COLS; j++) unused_edge_c = unused_edge_c ^ (^w_v[ROWS][j]) ^ wv_v[ROWS][j];
  end

  always_comb begin
    sel_row_c = '0;
    for (int j = 0; j < COLS; j++) sel_row_c[j*AW +: AW] = acc_w[sel_idx_c][j];
  end

  // Control FSM: load beats, flush the skew/array pipeline, then drain one row per handshake.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_row_q   <= '0;
      out_last_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            busy_q <= 1'b1;
            if (k_len == '0) begin
              state_q <= ST_FLUSH;
              cnt_q   <= KW'(FLUSH_LEN);
            end else begin
              state_q    <= ST_COMPUTE;
              cnt_q      <= k_len;
              in_ready_q <= 1'b1;
            end
          end
        end
        ST_COMPUTE: begin
          if (beat_c) begin
            if (cnt_q == KW'(1)) begin
              state_q    <= ST_FLUSH;
              cnt_q      <= KW'(FLUSH_LEN);
              in_ready_q <= 1'b0;
            end else begin
              cnt_q <= cnt_q - KW'(1);
            end
          end
        end
        ST_FLUSH: begin
          if (cnt_q == KW'(1)) begin
            state_q     <= ST_DRAIN;
            out_valid_q <= 1'b1;
            out_row_q   <= '0;
            out_data_q  <= sel_row_c;
            out_last_q  <= (ROWS == 1);
          end else begin
            cnt_q <= cnt_q - KW'(1);
          end
        end
        ST_DRAIN: begin
          if (out_ready) begin
            if (out_last_q) begin
              state_q     <= ST_IDLE;
              busy_q      <= 1'b0;
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
              out_row_q   <= '0;
              out_data_q  <= '0;
              done_q      <= 1'b1;
            end else begin
              out_row_q  <= row_nxt_c;
              out_data_q <= sel_row_c;
              out_last_q <= (row_nxt_c == RW'(ROWS - 1));
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy      = busy_q;
  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_row   = out_row_q;
  assign out_last  = out_last_q;
  assign done      = done_q;

endmodule

// File: tb/tb_systolic_array_os.sv
// Self-checking bench for systolic_array_os: table of directed jobs plus reset and
// drain-backpressure sequences. Runs a 4x4 array with DW=8, AW=16.
module tb_systolic_array_os;

  localparam int unsigned ROWS = 4;
  localparam int unsigned COLS = 4;
  localparam int unsigned DW   = 8;
  localparam int unsigned AW   = 16;
  localparam int unsigned KMAX = 4;
  localparam int          NV   = 6;

`ifdef SA_SATURATE_EN
  localparam logic [AW-1:0] OVF_EXP = 16'h7FFF;
`else
  localparam logic [AW-1:0] OVF_EXP = 16'hC000;
`endif

  logic                clk = 1'b0;
  logic                rstn = 1'b0;
  logic                start = 1'b0;
  logic [15:0]         k_len = '0;
  logic                busy;
  logic                in_valid = 1'b0;
  logic                in_ready;
  logic [ROWS*DW-1:0]  in_a = '0;
  logic [COLS*DW-1:0]  in_w = '0;
  logic                out_valid;
  logic                out_ready = 1'b0;
  logic [COLS*AW-1:0]  out_data;
  logic [1:0]          out_row;
  logic                out_last;
  logic                done;

  systolic_array_os #(
    .ROWS(ROWS),
    .COLS(COLS),
    .DW  (DW),
    .AW  (AW)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .start     (start),
    .k_len     (k_len),
    .busy      (busy),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_w      (in_w),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_row   (out_row),
    .out_last  (out_last),
    .done      (done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0]                      k;
    logic [7:0]                       vpat;
    logic [KMAX-1:0][ROWS*DW-1:0]     a;
    logic [KMAX-1:0][COLS*DW-1:0]     w;
    logic [ROWS-1:0][COLS*AW-1:0]     c;
  } vec_t;

  vec_t vecs [NV];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Drive one job from the table and compare every drained row; bp_row >= 0 stalls that row.
  task automatic run_job(input int v, input int bp_row);
    int   b;
    int   cyc;
    logic hs;
    out_ready = 1'b1;
    start     = 1'b1;
    k_len     = vecs[v].k;
    step();
    start = 1'b0;
    chk($sformatf("v%0d busy_after_start", v), 64'(busy), 64'd1);
    b   = 0;
    cyc = 0;
    while (b < int'(vecs[v].k) && cyc < 32) begin
      in_valid = vecs[v].vpat[cyc % 8];
      in_a     = vecs[v].a[b];
      in_w     = vecs[v].w[b];
      hs       = in_valid && in_ready;
      step();
      if (hs) b++;
      cyc++;
    end
    in_valid = 1'b0;
    chk($sformatf("v%0d beats_taken", v), 64'(b), 64'(vecs[v].k));
    chk($sformatf("v%0d in_ready_drop", v), 64'(in_ready), 64'd0);
    cyc = 0;
    while (!out_valid && cyc < 40) begin
      step();
      cyc++;
    end
    for (int r = 0; r < int'(ROWS); r++) begin
      chk($sformatf("v%0d r%0d out_valid", v, r), 64'(out_valid), 64'd1);
      chk($sformatf("v%0d r%0d out_row", v, r), 64'(out_row), 64'(r));
      chk($sformatf("v%0d r%0d out_data", v, r), 64'(out_data), 64'(vecs[v].c[r]));
      chk($sformatf("v%0d r%0d out_last", v, r), 64'(out_last), 64'(r == int'(ROWS) - 1));
      chk($sformatf("v%0d r%0d done_low", v, r), 64'(done), 64'd0);
      if (r == bp_row) begin
        out_ready = 1'b0;
        start     = 1'b1;
        k_len     = 16'd0;
        for (int s = 0; s < 5; s++) begin
          step();
          start = 1'b0;
          chk($sformatf("v%0d bp%0d valid", v, s), 64'(out_valid), 64'd1);
          chk($sformatf("v%0d bp%0d row", v, s), 64'(out_row), 64'(r));
          chk($sformatf("v%0d bp%0d data", v, s), 64'(out_data), 64'(vecs[v].c[r]));
        end
        out_ready = 1'b1;
      end
      step();
    end
    chk($sformatf("v%0d done_pulse", v), 64'(done), 64'd1);
    chk($sformatf("v%0d busy_idle", v), 64'(busy), 64'd0);
    chk($sformatf("v%0d out_valid_idle", v), 64'(out_valid), 64'd0);
    step();
    chk($sformatf("v%0d done_single", v), 64'(done), 64'd0);
    chk($sformatf("v%0d busy_stays_idle", v), 64'(busy), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int v = 0; v < NV; v++) begin
      vecs[v]      = '0;
      vecs[v].vpat = 8'hFF;
    end
    // v0 ones: every C entry is k_len = 3
    vecs[0].k = 16'd3;
    for (int b = 0; b < 3; b++) begin
      vecs[0].a[b] = {ROWS{8'd1}};
      vecs[0].w[b] = {COLS{8'd1}};
    end
    for (int r = 0; r < int'(ROWS); r++) vecs[0].c[r] = {COLS{16'd3}};
    // v1 identity with A[2][2] = -1, W[k][j] = 4k+j
    vecs[1].k = 16'd4;
    for (int kk = 0; kk < 4; kk++) begin
      for (int i = 0; i < int'(ROWS); i++)
        vecs[1].a[kk][i*DW +: DW] = (i != kk) ? 8'h00 : ((kk == 2) ? 8'hFF : 8'h01);
      for (int j = 0; j < int'(COLS); j++)
        vecs[1].w[kk][j*DW +: DW] = 8'(kk * 4 + j);
    end
    for (int i = 0; i < int'(ROWS); i++)
      for (int j = 0; j < int'(COLS); j++)
        vecs[1].c[i][j*AW +: AW] = (i == 2) ? 16'(-(i * 4 + j)) : 16'(i * 4 + j);
    // v2 ones with bubbles: in_valid 1,0,1,0,1
    vecs[2]      = vecs[0];
    vecs[2].vpat = 8'b0001_0101;
    // v3 k_len = 0: all zero rows
    vecs[3].k = 16'd0;
    // v4 overflow: (-128)*(-128)*3 = 49152 does not fit in 16 signed bits
    vecs[4].k = 16'd3;
    for (int b = 0; b < 3; b++) begin
      vecs[4].a[b] = {ROWS{8'h80}};
      vecs[4].w[b] = {COLS{8'h80}};
    end
    for (int r = 0; r < int'(ROWS); r++) vecs[4].c[r] = {COLS{OVF_EXP}};
    // v5 two distinct beats: C[i][j] = (i+1)(j-2) + (-i)(3)
    vecs[5].k = 16'd2;
    for (int i = 0; i < int'(ROWS); i++) begin
      vecs[5].a[0][i*DW +: DW] = 8'(i + 1);
      vecs[5].a[1][i*DW +: DW] = 8'(-i);
    end
    for (int j = 0; j < int'(COLS); j++) begin
      vecs[5].w[0][j*DW +: DW] = 8'(j - 2);
      vecs[5].w[1][j*DW +: DW] = 8'd3;
    end
    for (int i = 0; i < int'(ROWS); i++)
      for (int j = 0; j < int'(COLS); j++)
        vecs[5].c[i][j*AW +: AW] = 16'((i + 1) * (j - 2) - 3 * i);

    repeat (3) @(negedge clk);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset in_ready", 64'(in_ready), 64'd0);
    chk("reset out_valid", 64'(out_valid), 64'd0);
    chk("reset out_data", 64'(out_data), 64'd0);
    chk("reset out_row", 64'(out_row), 64'd0);
    chk("reset out_last", 64'(out_last), 64'd0);
    chk("reset done", 64'(done), 64'd0);
    rstn = 1'b1;
    step();

    run_job(0, -1);
    run_job(1, -1);
    run_job(2, -1);
    run_job(0, 1);
    run_job(3, -1);
    run_job(4, -1);
    run_job(5, -1);

    // Reset asserted in the middle of COMPUTE abandons the job.
    out_ready = 1'b1;
    start     = 1'b1;
    k_len     = 16'd4;
    step();
    start    = 1'b0;
    in_valid = 1'b1;
    in_a     = vecs[1].a[0];
    in_w     = vecs[1].w[0];
    step();
    in_a = vecs[1].a[1];
    in_w = vecs[1].w[1];
    step();
    chk("midjob busy", 64'(busy), 64'd1);
    chk("midjob in_ready", 64'(in_ready), 64'd1);
    rstn = 1'b0;
    #1;
    chk("rst busy", 64'(busy), 64'd0);
    chk("rst out_valid", 64'(out_valid), 64'd0);
    chk("rst in_ready", 64'(in_ready), 64'd0);
    chk("rst done", 64'(done), 64'd0);
    in_valid = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    for (int s = 0; s < 3; s++) begin
      step();
      chk($sformatf("post_rst%0d done", s), 64'(done), 64'd0);
      chk($sformatf("post_rst%0d busy", s), 64'(busy), 64'd0);
    end
    run_job(1, -1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
